// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, one-cycle overflow/underflow pulses and a selectable
// first-word-fall-through read mode.
//
// Handshake: a write is taken on a rising edge when w_en=1 and full=0; a read
// (or FWFT pop) is taken when r_en=1 and empty=0. Both flags are the values
// seen before the edge. A request against the wrong flag is dropped and
// reported by a registered pulse in the following cycle.
module synchronous_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      w_en,
  input  logic                      r_en,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  localparam logic [PTR_WIDTH:0] C_DEPTH = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] C_AF    = (PTR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0] C_AE    = (PTR_WIDTH + 1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_WIDTH:0]    r_wptr;
  logic [PTR_WIDTH:0]    r_rptr;
  logic [PTR_WIDTH:0]    r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [PTR_WIDTH-1:0]  w_waddr;
  logic [PTR_WIDTH-1:0]  w_raddr;

  // Flags decode straight from the count register, so they are registered
  // state and reflect everything accepted up to the previous edge.
  assign full         = (r_count == C_DEPTH);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // When full, the read still goes through and only the write is dropped;
  // when empty, the write goes through and only the read is dropped.
  assign w_wr_acc = w_en & ~full;
  assign w_rd_acc = r_en & ~empty;
  assign w_waddr  = r_wptr[PTR_WIDTH-1:0];
  assign w_raddr  = r_rptr[PTR_WIDTH-1:0];

  // Storage array: written on an accepted write, deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_waddr] <= data_in;
    end
  end

  // Pointers and occupancy; pointers carry one extra bit and wrap mod 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Error pulses: one cycle after a request that hit the opposing flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_en & full;
      r_underflow <= r_en & empty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is visible as soon as it exists; zero while empty.
      assign data_out = empty ? '0 : r_mem[w_raddr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_dout;

      // Output register loads the head word on an accepted read, holds otherwise.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dout <= '0;
        end else if (w_rd_acc) begin
          r_dout <= r_mem[w_raddr];
        end
      end

      assign data_out = r_dout;
    end
  endgenerate

endmodule
